// File: rtl/gyruss_rom_dl_tx.sv
// Transmit end of the Gyruss ROM download bus: buffers host bytes in a small FIFO and replays
// them as gapped ROMEN strobes. Define GYRUSS_DL_SUM_EN to add the DL_SUM byte checksum output.
module gyruss_rom_dl_tx #(
    parameter int ROM_SIZE   = 98304,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP        = 1
) (
    input  logic        ROMCL,
    input  logic        RESET_N,
    input  logic        DL_ACT,
    input  logic        DL_WR,
    input  logic [24:0] DL_ADDR,
    input  logic [7:0]  DL_DATA,
    output logic        DL_WAIT,
    output logic [16:0] ROMAD,
    output logic [7:0]  ROMDT,
    output logic        ROMEN,
    output logic        CORE_RST,
    output logic        DL_DONE,
    output logic [7:0]  DL_DROP,
`ifdef GYRUSS_DL_SUM_EN
    output logic [15:0] DL_SUM,
`endif
    output logic [1:0]  DBG_STATE
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [24:0]   ROM_LIMIT = 25'(ROM_SIZE);
    localparam logic [2:0]    GAP_L     = 3'(GAP);
    localparam logic [CW-1:0] DEPTH_L   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_L    = CW'(FIFO_DEPTH - 1);

    // Host handshake: a byte transfers on any edge with DL_WR=1 and DL_ACT=1 outside DRAIN;
    // DL_WAIT is advisory back-pressure, and bytes offered while the FIFO is full are dropped.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [24:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    gap_q, gap_d;
    logic [7:0]    drop_q, drop_d;
    logic          wait_q;
    logic [16:0]   romad_q;
    logic [7:0]    romdt_q;
    logic          romen_q;
    logic          core_rst, dl_done;

    logic accept, in_range, full, push, reject, pop, enter_load;

    always_comb begin
        accept     = DL_WR & DL_ACT & (state_q != ST_DRAIN);
        in_range   = DL_ADDR < ROM_LIMIT;
        full       = count_q == DEPTH_L;
        push       = accept & in_range & ~full;
        reject     = accept & ~push;
        pop        = (count_q != '0) & (gap_q == 3'd0);
        enter_load = ((state_q == ST_IDLE) | (state_q == ST_DONE)) & DL_ACT;
    end

    always_comb begin
        state_d  = state_q;
        core_rst = 1'b1;
        dl_done  = 1'b0;
        case (state_q)
            ST_IDLE:  if (DL_ACT) state_d = ST_LOAD;
            ST_LOAD:  if (!DL_ACT) state_d = ST_DRAIN;
            ST_DRAIN: if ((count_q == '0) && (gap_q == 3'd0)) state_d = ST_DONE;
            ST_DONE: begin
                core_rst = 1'b0;
                dl_done  = 1'b1;
                if (DL_ACT) state_d = ST_LOAD;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        gap_d   = gap_q;
        if (pop) begin
            gap_d = GAP_L;
        end else if (gap_q != 3'd0) begin
            gap_d = gap_q - 3'd1;
        end
        drop_d = drop_q;
        if (enter_load) begin
            drop_d = reject ? 8'd1 : 8'd0;
        end else if (reject && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge ROMCL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= 3'd0;
            drop_q   <= 8'd0;
            wait_q   <= 1'b0;
            romad_q  <= 17'd0;
            romdt_q  <= 8'd0;
            romen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            gap_q   <= gap_d;
            drop_q  <= drop_d;
            wait_q  <= count_d >= WAIT_L;
            romen_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                romad_q  <= mem_q[rd_ptr_q][24:8];
                romdt_q  <= mem_q[rd_ptr_q][7:0];
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge ROMCL) begin
        if (push) mem_q[wr_ptr_q] <= {DL_ADDR[16:0], DL_DATA};
    end

`ifdef GYRUSS_DL_SUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge ROMCL or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_q <= 16'd0;
        end else if (enter_load) begin
            sum_q <= 16'd0;
        end else if (pop) begin
            sum_q <= sum_q + {8'd0, mem_q[rd_ptr_q][7:0]};
        end
    end

    assign DL_SUM = sum_q;
`endif

    assign DL_WAIT   = wait_q;
    assign ROMAD     = romad_q;
    assign ROMDT     = romdt_q;
    assign ROMEN     = romen_q;
    assign CORE_RST  = core_rst;
    assign DL_DONE   = dl_done;
    assign DL_DROP   = drop_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_gyruss_rom_dl_tx.sv
// Bench for gyruss_rom_dl_tx: host driver, cycle model of the download rules, strobe scoreboard.
// Build with GYRUSS_DL_SUM_EN defined to also cover DL_SUM.
module tb_gyruss_rom_dl_tx;

    localparam int ROM_SIZE = 98304;
    localparam int DEPTH    = 4;
    localparam int GAP      = 1;

    logic        ROMCL, RESET_N, DL_ACT, DL_WR;
    logic [24:0] DL_ADDR;
    logic [7:0]  DL_DATA;
    logic        DL_WAIT, ROMEN, CORE_RST, DL_DONE;
    logic [16:0] ROMAD;
    logic [7:0]  ROMDT, DL_DROP;
    logic [1:0]  DBG_STATE;
`ifdef GYRUSS_DL_SUM_EN
    logic [15:0] DL_SUM;
`endif

    gyruss_rom_dl_tx #(.ROM_SIZE(ROM_SIZE), .FIFO_DEPTH(DEPTH), .GAP(GAP)) dut (
        .ROMCL(ROMCL), .RESET_N(RESET_N), .DL_ACT(DL_ACT), .DL_WR(DL_WR),
        .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA), .DL_WAIT(DL_WAIT), .ROMAD(ROMAD),
        .ROMDT(ROMDT), .ROMEN(ROMEN), .CORE_RST(CORE_RST), .DL_DONE(DL_DONE),
        .DL_DROP(DL_DROP),
`ifdef GYRUSS_DL_SUM_EN
        .DL_SUM(DL_SUM),
`endif
        .DBG_STATE(DBG_STATE)
    );

    // Clock and reset
    initial ROMCL = 1'b0;
    always #5 ROMCL = ~ROMCL;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model (IDLE=0 LOAD=1 DRAIN=2 DONE=3); exp_q holds {addr17,data} in host order.
    logic [24:0] exp_q[$];
    int   m_state, m_occ, m_gap, m_drop;
    bit   m_wait, m_strobe;
    logic [15:0] exp_sum;
    int   cyc = 0;
    int   last_cyc = -100;
    logic [16:0] last_ad;

    always @(posedge ROMCL or negedge RESET_N) begin
        if (!RESET_N) begin
            m_state = 0; m_occ = 0; m_gap = 0; m_drop = 0;
            m_wait = 0; m_strobe = 0; exp_sum = 16'd0; last_cyc = -100;
            exp_q.delete();
        end else begin
            bit acc, ok, pop, enter;
            int old_occ, old_gap;
            acc   = DL_WR && DL_ACT && (m_state != 2);
            ok    = acc && (DL_ADDR < ROM_SIZE) && (m_occ < DEPTH);
            pop   = (m_occ > 0) && (m_gap == 0);
            enter = ((m_state == 0) || (m_state == 3)) && DL_ACT;
            old_occ = m_occ;
            old_gap = m_gap;
            if (ok) exp_q.push_back({DL_ADDR[16:0], DL_DATA});
            if (enter) begin
                m_drop  = (acc && !ok) ? 1 : 0;
                exp_sum = 16'd0;
            end else if (acc && !ok && m_drop < 255) begin
                m_drop++;
            end
            m_strobe = pop;
            m_occ    = m_occ + int'(ok) - int'(pop);
            m_gap    = pop ? GAP : ((m_gap > 0) ? m_gap - 1 : 0);
            case (m_state)
                0: if (DL_ACT) m_state = 1;
                1: if (!DL_ACT) m_state = 2;
                2: if (old_occ == 0 && old_gap == 0) m_state = 3;
                default: if (DL_ACT) m_state = 1;
            endcase
            m_wait = m_occ >= DEPTH - 1;
        end
    end

    // Scoreboard / per-cycle monitor, sampled on the falling edge
    always @(negedge ROMCL) begin
        cyc++;
        check("romen", ROMEN, m_strobe);
        if (ROMEN && m_strobe) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                logic [24:0] e;
                e = exp_q.pop_front();
                check("romad", ROMAD, e[24:8]);
                check("romdt", ROMDT, e[7:0]);
                exp_sum = exp_sum + {8'd0, e[7:0]};
                check("strobe_gap", (cyc - last_cyc) >= GAP + 1, 1);
                last_cyc = cyc;
                last_ad  = ROMAD;
            end
        end
        check("dl_wait", DL_WAIT, m_wait);
        check("core_rst", CORE_RST, (m_state != 3));
        check("dl_done", DL_DONE, (m_state == 3));
        check("dl_drop", DL_DROP, m_drop);
        check("state", DBG_STATE, m_state);
    end

    // Driver tasks (called at a falling edge, return at the next one)
    task automatic host_write(input logic [24:0] a, input logic [7:0] d, input bit honor);
        int n = 0;
        while (honor && DL_WAIT && n < 200) begin
            DL_WR = 1'b0;
            @(negedge ROMCL);
            n++;
        end
        if (n >= 200) check("wait_timeout", 1, 0);
        DL_WR   = 1'b1;
        DL_ADDR = a;
        DL_DATA = d;
        @(negedge ROMCL);
        DL_WR = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!DL_DONE && n < 500) begin
            @(negedge ROMCL);
            n++;
        end
        check("done_timeout", DL_DONE, 1);
    endtask

    initial begin
        RESET_N = 1'b0; DL_ACT = 1'b0; DL_WR = 1'b0; DL_ADDR = '0; DL_DATA = '0;
        repeat (3) @(negedge ROMCL);
        check("rst_romen", ROMEN, 0);
        check("rst_romad", ROMAD, 0);
        check("rst_romdt", ROMDT, 0);
        check("rst_core_rst", CORE_RST, 1);
        check("rst_done", DL_DONE, 0);
        check("rst_wait", DL_WAIT, 0);
        check("rst_drop", DL_DROP, 0);
        check("rst_state", DBG_STATE, 0);
`ifdef GYRUSS_DL_SUM_EN
        check("rst_sum", DL_SUM, 0);
`endif
        RESET_N = 1'b1;
        @(negedge ROMCL);

        // Single write raised together with DL_ACT: strobe two cycles later, one cycle wide
        DL_ACT = 1'b1;
        host_write(25'h10, 8'hA5, 1);
        @(negedge ROMCL);
        check("t1_romen", ROMEN, 1);
        check("t1_romad", ROMAD, 17'h10);
        check("t1_romdt", ROMDT, 8'hA5);
        DL_ACT = 1'b0;
        @(negedge ROMCL);
        check("t1_romen_low", ROMEN, 0);
        check("t1_romad_hold", ROMAD, 17'h10);
        wait_done();
        check("t1_core_rst", CORE_RST, 0);
        check("t1_done", DL_DONE, 1);

        // Eight writes honouring back-pressure: nothing dropped
        DL_ACT = 1'b1;
        for (int i = 0; i < 8; i++)
            host_write(25'($urandom_range(0, ROM_SIZE - 1)), 8'($urandom_range(0, 255)), 1);
        DL_ACT = 1'b0;
        wait_done();
        check("t2_drop", DL_DROP, 0);

        // Twelve back-to-back writes ignoring DL_WAIT overflow the FIFO three times
        DL_ACT = 1'b1;
        for (int i = 0; i < 12; i++)
            host_write(25'(i * 3), 8'(8'h40 + i), 0);
        DL_ACT = 1'b0;
        wait_done();
        check("t3_drop", DL_DROP, 3);

        // Address range boundary
        DL_ACT = 1'b1;
        host_write(25'd98304, 8'h11, 1);
        host_write(25'h1FFFF, 8'h22, 1);
        host_write(25'd98303, 8'h3C, 1);
        DL_ACT = 1'b0;
        wait_done();
        check("t4_drop", DL_DROP, 2);
        check("t4_last_ad", last_ad, 17'h17FFF);

        // Checksum wraps within 16 bits and clears on the next LOAD entry
        DL_ACT = 1'b1;
        host_write(25'h100, 8'hFF, 1);
        host_write(25'h101, 8'hFF, 1);
        host_write(25'h102, 8'h02, 1);
        DL_ACT = 1'b0;
        wait_done();
`ifdef GYRUSS_DL_SUM_EN
        check("t5_sum", DL_SUM, 16'h0200);
        check("t5_sum_model", DL_SUM, exp_sum);
`endif
        DL_ACT = 1'b1;
        @(negedge ROMCL);
`ifdef GYRUSS_DL_SUM_EN
        check("t5_sum_clear", DL_SUM, 0);
`endif
        host_write(25'h200, 8'h11, 1);
        DL_ACT = 1'b0;
        wait_done();
`ifdef GYRUSS_DL_SUM_EN
        check("t5_sum2", DL_SUM, 16'h0011);
`endif

        // Reset pulse with three bytes still buffered
        DL_ACT = 1'b1;
        for (int i = 0; i < 6; i++)
            host_write(25'(16'h300 + i), 8'(8'h90 + i), 0);
        #2;
        RESET_N = 1'b0;
        DL_ACT  = 1'b0;
        #1;
        check("t6_romen_async", ROMEN, 0);
        check("t6_core_rst", CORE_RST, 1);
        check("t6_state", DBG_STATE, 0);
        check("t6_wait", DL_WAIT, 0);
        @(negedge ROMCL);
        RESET_N = 1'b1;
        repeat (8) @(negedge ROMCL);
        check("t6_state_idle", DBG_STATE, 0);
        check("t6_quiet", ROMEN, 0);

        // Randomised session: sparse writes, some out of range, some ignoring back-pressure
        DL_ACT = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [24:0] a;
            repeat ($urandom_range(0, 2)) @(negedge ROMCL);
            a = ($urandom_range(0, 7) == 0) ? 25'(ROM_SIZE + $urandom_range(0, 100))
                                             : 25'($urandom_range(0, ROM_SIZE - 1));
            host_write(a, 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
        end
        DL_ACT = 1'b0;
        wait_done();
        repeat (2) @(negedge ROMCL);
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
